// File: rtl/drive_cmd_scheduler.sv
// drive_cmd_scheduler: arbitrates drive-command requesters onto the shared JSON/UART frame sender.
// Build option CMD_DEDUP_EN: requests repeating last_cmd (keepalive not due) are acknowledged and dropped.
module drive_cmd_scheduler #(
    parameter int N_REQ             = 3,
    parameter int MIN_GAP_CYCLES    = 50_000,
    parameter int KEEPALIVE_CYCLES  = 25_000_000,
    parameter int TX_TIMEOUT_CYCLES = 5_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [3*N_REQ-1:0] req_cmd,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               estop,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [2:0]         tx_cmd,
    output logic [2:0]         last_cmd,
    output logic [15:0]        frames_sent,
    output logic               tx_error,
    output logic               sched_busy
);

    // state     | meaning
    // ----------+------------------------------------------------------------
    // IDLE      | choose estop STOP, a requester, or a keepalive re-send
    // LAUNCH    | tx_cmd loaded; waits for tx_busy low, then pulses tx_start
    // WAIT_DONE | frame in flight; leaves on tx_done or on timeout
    // GAP       | enforced quiet time of MIN_GAP_CYCLES before the next pick
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam logic [2:0]  CMD_STOP     = 3'b000;
    localparam bit          KA_EN        = (KEEPALIVE_CYCLES > 0);
    localparam bit          GAP_EN       = (MIN_GAP_CYCLES > 0);
    localparam logic [31:0] KA_LIMIT     = KA_EN ? 32'(KEEPALIVE_CYCLES - 1) : 32'd0;
    localparam logic [31:0] GAP_LOAD     = GAP_EN ? 32'(MIN_GAP_CYCLES - 1) : 32'd0;
    localparam logic [31:0] TIMEOUT_LOAD = (TX_TIMEOUT_CYCLES > 0) ? 32'(TX_TIMEOUT_CYCLES - 1) : 32'd0;

    state_t             state;
    logic [31:0]        ka_cnt;
    logic [31:0]        timer;
    logic               ka_due;
    logic [N_REQ-1:0]   pending;
    logic [N_REQ-1:0]   grant;
    logic [2:0]         grant_cmd;
    logic               req_found;
    logic               take_stop;
    logic               dup_drop;

    assign ka_due    = KA_EN && (ka_cnt >= KA_LIMIT);
    assign take_stop = estop && ((last_cmd != CMD_STOP) || ka_due);

    // A requester already acknowledged this cycle is masked so a discarded
    // request still held for one more cycle is not acknowledged twice.
    assign pending = req_valid & ~req_ready;

    always_comb begin
        grant     = '0;
        grant_cmd = CMD_STOP;
        req_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_cmd = req_cmd[3*i +: 3];
                req_found = 1'b1;
            end
        end
    end

`ifdef CMD_DEDUP_EN
    assign dup_drop = (grant_cmd == last_cmd) && !ka_due;
`else
    assign dup_drop = 1'b0;
`endif

    // GAP holds for MIN_GAP_CYCLES cycles after the cycle tx_done is seen;
    // IDLE and LAUNCH then add two more cycles before tx_start is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ka_cnt      <= '0;
            timer       <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_cmd      <= CMD_STOP;
            last_cmd    <= CMD_STOP;
            frames_sent <= '0;
            tx_error    <= 1'b0;
            sched_busy  <= 1'b0;
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            if (state != LAUNCH && ka_cnt != 32'hFFFF_FFFF)
                ka_cnt <= ka_cnt + 32'd1;

            case (state)
                IDLE: begin
                    if (take_stop) begin
                        tx_cmd     <= CMD_STOP;
                        state      <= LAUNCH;
                        sched_busy <= 1'b1;
                    end else if (req_found) begin
                        req_ready <= grant;
                        if (!estop && !dup_drop) begin
                            tx_cmd     <= grant_cmd;
                            state      <= LAUNCH;
                            sched_busy <= 1'b1;
                        end
                    end else if (ka_due) begin
                        tx_cmd     <= last_cmd;
                        state      <= LAUNCH;
                        sched_busy <= 1'b1;
                    end
                end

                LAUNCH: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        last_cmd <= tx_cmd;
                        if (frames_sent != 16'hFFFF)
                            frames_sent <= frames_sent + 16'd1;
                        ka_cnt   <= '0;
                        timer    <= TIMEOUT_LOAD;
                        state    <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (tx_done || timer == '0) begin
                        if (!tx_done)
                            tx_error <= 1'b1;
                        if (GAP_EN) begin
                            timer <= GAP_LOAD;
                            state <= GAP;
                        end else begin
                            state      <= IDLE;
                            sched_busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end

                GAP: begin
                    if (timer == '0) begin
                        state      <= IDLE;
                        sched_busy <= 1'b0;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler: main instance (gap 4, timeout 50, no keepalive)
// and a keepalive instance (keepalive 100) with an automatic tx_done responder.
module tb_drive_cmd_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [8:0]  req_cmd;
    logic [2:0]  req_ready;
    logic        estop;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_start;
    logic [2:0]  tx_cmd;
    logic [2:0]  last_cmd;
    logic [15:0] frames_sent;
    logic        tx_error;
    logic        sched_busy;

    logic [2:0]  ka_req_valid;
    logic [8:0]  ka_req_cmd;
    logic [2:0]  ka_req_ready;
    logic        ka_tx_done;
    logic        ka_tx_start;
    logic [2:0]  ka_tx_cmd;
    logic [2:0]  ka_last_cmd;
    logic [15:0] ka_frames_sent;
    logic        ka_tx_error;
    logic        ka_sched_busy;
    logic        ka_estop;
    logic        ka_tx_busy;

    int n_pass;
    int n_checks;
    int cyc;
    int done_at;
    int ka_n;
    int ka_starts [8];

    drive_cmd_scheduler #(
        .N_REQ(3), .MIN_GAP_CYCLES(4), .KEEPALIVE_CYCLES(0), .TX_TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .estop(estop), .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_cmd(tx_cmd),
        .last_cmd(last_cmd), .frames_sent(frames_sent), .tx_error(tx_error), .sched_busy(sched_busy)
    );

    drive_cmd_scheduler #(
        .N_REQ(3), .MIN_GAP_CYCLES(4), .KEEPALIVE_CYCLES(100), .TX_TIMEOUT_CYCLES(50)
    ) dut_ka (
        .clk(clk), .rst(rst), .req_valid(ka_req_valid), .req_cmd(ka_req_cmd), .req_ready(ka_req_ready),
        .estop(ka_estop), .tx_busy(ka_tx_busy), .tx_done(ka_tx_done), .tx_start(ka_tx_start),
        .tx_cmd(ka_tx_cmd), .last_cmd(ka_last_cmd), .frames_sent(ka_frames_sent),
        .tx_error(ka_tx_error), .sched_busy(ka_sched_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse tx_done for one cycle, then sit out the 4-cycle gap; IDLE is visible afterwards.
    task automatic finish_frame();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        repeat (4) step();
    endtask

    // Keepalive instance: cycle counter, tx_start log, tx_done returned 3 cycles after tx_start.
    initial begin
        ka_tx_done = 1'b0;
        cyc        = 0;
        done_at    = -1;
        ka_n       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) cyc++;
            ka_tx_done = (cyc == done_at);
            if (ka_tx_start) begin
                if (ka_n < 8) ka_starts[ka_n] = cyc;
                ka_n++;
                done_at = cyc + 3;
            end
        end
    end

    initial begin
        n_pass       = 0;
        n_checks     = 0;
        rst          = 1'b1;
        req_valid    = '0;
        req_cmd      = '0;
        estop        = 1'b0;
        tx_busy      = 1'b0;
        tx_done      = 1'b0;
        ka_req_valid = '0;
        ka_req_cmd   = '0;
        ka_estop     = 1'b0;
        ka_tx_busy   = 1'b0;
        repeat (3) step();

        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_cmd", 32'(tx_cmd), 0);
        chk("rst_last_cmd", 32'(last_cmd), 0);
        chk("rst_frames", 32'(frames_sent), 0);
        chk("rst_tx_error", 32'(tx_error), 0);
        chk("rst_sched_busy", 32'(sched_busy), 0);

        // Single request: ready one cycle later, tx_start the cycle after.
        @(negedge clk);
        rst          = 1'b0;
        req_valid    = 3'b010;
        req_cmd      = 9'b000_100_000;
        ka_req_valid = 3'b001;
        ka_req_cmd   = 9'b000_000_101;
        step();
        chk("t1_ready", 32'(req_ready), 2);
        chk("t1_no_start_yet", 32'(tx_start), 0);
        chk("t1_busy", 32'(sched_busy), 1);
        req_valid    = '0;
        ka_req_valid = '0;
        step();
        chk("t1_start", 32'(tx_start), 1);
        chk("t1_tx_cmd", 32'(tx_cmd), 4);
        chk("t1_frames", 32'(frames_sent), 1);
        chk("t1_last_cmd", 32'(last_cmd), 4);
        step();
        chk("t1_start_pulse", 32'(tx_start), 0);
        finish_frame();
        chk("t1_idle", 32'(sched_busy), 0);

        // Two requesters: index 0 first, index 2 after the gap.
        req_valid = 3'b101;
        req_cmd   = 9'b010_000_001;
        step();
        chk("t2_ready0", 32'(req_ready), 1);
        req_valid = 3'b100;
        step();
        chk("t2_start0", 32'(tx_start), 1);
        chk("t2_cmd0", 32'(tx_cmd), 1);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t2_gap_quiet", 32'({tx_start, req_ready}), 0);
        end
        chk("t2_gap_over", 32'(sched_busy), 0);
        step();
        chk("t2_ready2", 32'(req_ready), 4);
        req_valid = '0;
        step();
        chk("t2_start2", 32'(tx_start), 1);
        chk("t2_cmd2", 32'(tx_cmd), 2);
        chk("t2_frames", 32'(frames_sent), 3);
        step();
        finish_frame();

        // Estop: STOP goes first, held request is acknowledged and discarded.
        req_valid = 3'b001;
        req_cmd   = 9'b000_000_101;
        step();
        req_valid = '0;
        step();
        step();
        finish_frame();
        chk("t3_last_fast", 32'(last_cmd), 5);
        estop     = 1'b1;
        req_valid = 3'b010;
        req_cmd   = 9'b000_100_000;
        step();
        chk("t3_no_ack_yet", 32'(req_ready), 0);
        chk("t3_stop_loaded", 32'(tx_cmd), 0);
        step();
        chk("t3_stop_start", 32'(tx_start), 1);
        chk("t3_last_stop", 32'(last_cmd), 0);
        step();
        finish_frame();
        step();
        chk("t3_discard_ack", 32'(req_ready), 2);
        chk("t3_discard_idle", 32'(sched_busy), 0);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_estop_quiet", 32'({tx_start, sched_busy, req_ready}), 0);
        end
        chk("t3_frames", 32'(frames_sent), 5);
        estop = 1'b0;

        // tx_done in the same cycle as the timeout counts as done.
        req_valid = 3'b001;
        req_cmd   = 9'b000_000_001;
        step();
        req_valid = '0;
        step();
        chk("t4_start", 32'(tx_start), 1);
        repeat (49) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t4_no_error", 32'(tx_error), 0);
        chk("t4_in_gap", 32'(sched_busy), 1);
        repeat (4) step();
        chk("t4_idle", 32'(sched_busy), 0);

        // Timeout: no tx_done at all.
        req_valid = 3'b001;
        req_cmd   = 9'b000_000_010;
        step();
        req_valid = '0;
        step();
        chk("t5_start", 32'(tx_start), 1);
        repeat (49) step();
        chk("t5_error_early", 32'(tx_error), 0);
        step();
        chk("t5_error", 32'(tx_error), 1);
        chk("t5_in_gap", 32'(sched_busy), 1);
        repeat (4) step();
        chk("t5_idle", 32'(sched_busy), 0);

        // Next request still served, held in LAUNCH while tx_busy.
        tx_busy   = 1'b1;
        req_valid = 3'b100;
        req_cmd   = 9'b011_000_000;
        step();
        chk("t6_ready", 32'(req_ready), 4);
        req_valid = '0;
        step();
        step();
        chk("t6_busy_hold", 32'(tx_start), 0);
        chk("t6_busy_sched", 32'(sched_busy), 1);
        tx_busy = 1'b0;
        step();
        chk("t6_start", 32'(tx_start), 1);
        chk("t6_cmd", 32'(tx_cmd), 3);
        chk("t6_frames", 32'(frames_sent), 8);
        chk("t6_error_sticky", 32'(tx_error), 1);
        step();
        finish_frame();

        // Same command re-requested.
        req_valid = 3'b010;
        req_cmd   = 9'b000_011_000;
        step();
        chk("t7_ready", 32'(req_ready), 2);
        req_valid = '0;
        step();
`ifdef CMD_DEDUP_EN
        chk("t7_dedup_no_start", 32'(tx_start), 0);
        chk("t7_dedup_frames", 32'(frames_sent), 8);
        chk("t7_dedup_idle", 32'(sched_busy), 0);
`else
        chk("t7_repeat_start", 32'(tx_start), 1);
        chk("t7_repeat_frames", 32'(frames_sent), 9);
        step();
        finish_frame();
`endif

        // Keepalive instance: start at cycle 2, then every 101 cycles with last_cmd.
        for (int k = 0; k < 2000 && cyc < 320; k++) step();
        chk("ka_reached_end", 32'(cyc >= 320), 1);
        chk("ka_count", 32'(ka_n), 4);
        chk("ka_start0", 32'(ka_starts[0]), 2);
        chk("ka_start1", 32'(ka_starts[1]), 103);
        chk("ka_start2", 32'(ka_starts[2]), 204);
        chk("ka_start3", 32'(ka_starts[3]), 305);
        chk("ka_tx_cmd", 32'(ka_tx_cmd), 5);
        chk("ka_last_cmd", 32'(ka_last_cmd), 5);
        chk("ka_frames", 32'(ka_frames_sent), 4);
        chk("ka_no_error", 32'(ka_tx_error), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
